// File: rtl/outer_seq.sv
// outer_seq: ForthSuper outer interpreter, walks one TIB line token by token.
// Define OUTER_SHORT_LIT_EN to compile values below 2^MSZ as LIT8_OP + one byte.
module outer_seq #(
   parameter int TIB     = 'h0,
   parameter int MSZ     = 8,
   parameter int DSZ     = 32,
   parameter int ASZ     = 17,
   parameter int LIT_OP  = 'h02,
   parameter int LIT8_OP = 'h03
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           cmp,
   input  logic [ASZ-1:0] ctx0,
   input  logic [ASZ-1:0] here0,
   output logic           fdr_en,
   output logic [ASZ-1:0] fdr_aw,
   output logic [ASZ-1:0] fdr_ctx,
   input  logic           fdr_bsy,
   input  logic           fdr_hit,
   input  logic [MSZ-1:0] fdr_vw,
   input  logic [ASZ-1:0] fdr_tib,
   output logic           a2i_en,
   output logic [ASZ-1:0] a2i_tib,
   input  logic           a2i_bsy,
   input  logic           a2i_err,
   input  logic [DSZ-1:0] a2i_vo,
   input  logic [ASZ-1:0] a2i_tib_o,
   output logic           exe_en,
   output logic [ASZ-1:0] exe_pfa,
   output logic [MSZ-1:0] exe_op,
   input  logic           exe_bsy,
   output logic           cma_en,
   output logic [ASZ-1:0] cma_ai,
   output logic [MSZ-1:0] cma_vi,
   input  logic           cma_bsy,
   output logic           ss_push,
   output logic [DSZ-1:0] ss_v,
   output logic [ASZ-1:0] tib,
   output logic [ASZ-1:0] here,
   output logic           bsy,
   output logic           err,
   output logic [7:0]     tok_cnt
);
   localparam int NB = DSZ / MSZ;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [ASZ-1:0] TIB_A = ASZ'(TIB);
   localparam logic [MSZ-1:0] LIT_B = MSZ'(LIT_OP);
   localparam logic [MSZ-1:0] LIT8_B = MSZ'(LIT8_OP);

   typedef enum logic [3:0] {
      IDLE, FND, EXE, CMA, A2I, LIT, NUM, PSH, ERR, DONE
   } state_t;

   state_t         st;
   logic           fst;
   logic           cmp_q;
   logic           sht;
   logic           sht_nx;
   logic [KW-1:0]  k;
   logic [KW-1:0]  k_last;
   logic [ASZ-1:0] ctx;
   logic [ASZ-1:0] tib_q;
   logic [ASZ-1:0] here_q;
   logic [ASZ-1:0] pfa;
   logic [MSZ-1:0] op;
   logic [DSZ-1:0] v;
   logic [MSZ-1:0] vb;
   logic           err_q;
   logic [7:0]     cnt;
   logic           fdr_done;
   logic           a2i_done;
   logic           exe_done;
   logic           cma_done;

`ifdef OUTER_SHORT_LIT_EN
   assign sht_nx = (a2i_vo >> MSZ) == '0;
`else
   assign sht_nx = 1'b0;
`endif

   // the entry cycle of every state (and of every NUM byte) ignores bsy
   assign fdr_done = !fst && !fdr_bsy;
   assign a2i_done = !fst && !a2i_bsy;
   assign exe_done = !fst && !exe_bsy;
   assign cma_done = !fst && !cma_bsy;

   assign k_last = sht ? '0 : KW'(NB - 1);
   assign vb     = MSZ'(v >> (MSZ * int'(k)));

   assign fdr_en  = st == FND;
   assign fdr_aw  = tib_q;
   assign fdr_ctx = ctx;
   assign a2i_en  = st == A2I;
   assign a2i_tib = tib_q;
   assign exe_en  = st == EXE;
   assign exe_pfa = pfa;
   assign exe_op  = op;
   assign cma_en  = st inside {CMA, LIT, NUM};
   assign ss_push = st == PSH;
   assign ss_v    = v;
   assign tib     = tib_q;
   assign here    = here_q;
   assign bsy     = !(st inside {IDLE, ERR, DONE});
   assign err     = err_q;
   assign tok_cnt = cnt;

   always_comb begin
      cma_ai = '0;
      cma_vi = '0;
      unique case (1'b1)
         st == CMA: begin
            cma_ai = here_q;
            cma_vi = op;
         end
         st == LIT: begin
            cma_ai = here_q;
            cma_vi = sht ? LIT8_B : LIT_B;
         end
         st == NUM: begin
            cma_ai = here_q + ASZ'(k);
            cma_vi = vb;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st     <= IDLE;
         fst    <= 1'b0;
         cmp_q  <= 1'b0;
         sht    <= 1'b0;
         k      <= '0;
         ctx    <= '0;
         tib_q  <= TIB_A;
         here_q <= '0;
         pfa    <= '0;
         op     <= '0;
         v      <= '0;
         err_q  <= 1'b0;
         cnt    <= '0;
      end else if (!en) begin
         st  <= IDLE;
         fst <= 1'b0;
      end else begin
         fst <= 1'b0;
         unique case (st)
            IDLE: begin
               ctx    <= ctx0;
               here_q <= here0;
               tib_q  <= TIB_A;
               err_q  <= 1'b0;
               cnt    <= '0;
               fst    <= 1'b1;
               st     <= FND;
            end
            FND: if (fdr_done) begin
               tib_q <= fdr_tib;
               cmp_q <= cmp;
               fst   <= 1'b1;
               if (fdr_hit) begin
                  op  <= fdr_vw;
                  pfa <= fdr_tib;
                  st  <= cmp ? CMA : EXE;
               end else if (fdr_vw != '0) begin
                  st <= A2I;
               end else begin
                  tib_q <= TIB_A;
                  st    <= DONE;
               end
            end
            EXE: if (exe_done) begin
               cnt <= cnt + 8'd1;
               fst <= 1'b1;
               st  <= FND;
            end
            CMA: if (cma_done) begin
               here_q <= here_q + ASZ'(1);
               cnt    <= cnt + 8'd1;
               fst    <= 1'b1;
               st     <= FND;
            end
            A2I: if (a2i_done) begin
               fst <= 1'b1;
               if (a2i_err) begin
                  err_q <= 1'b1;
                  tib_q <= TIB_A;
                  st    <= ERR;
               end else begin
                  tib_q <= a2i_tib_o;
                  v     <= a2i_vo;
                  sht   <= sht_nx;
                  st    <= cmp_q ? LIT : PSH;
               end
            end
            PSH: begin
               cnt <= cnt + 8'd1;
               fst <= 1'b1;
               st  <= FND;
            end
            LIT: if (cma_done) begin
               here_q <= here_q + ASZ'(1);
               k      <= '0;
               fst    <= 1'b1;
               st     <= NUM;
            end
            // here stays on the literal base until the last byte lands
            NUM: if (cma_done) begin
               fst <= 1'b1;
               if (k == k_last) begin
                  here_q <= here_q + ASZ'(k) + ASZ'(1);
                  cnt    <= cnt + 8'd1;
                  st     <= FND;
               end else begin
                  k <= k + KW'(1);
               end
            end
            ERR, DONE: ;
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/outer_seq.md
# outer_seq

Parametrised outer-interpreter sequencer for the ForthSuper core. It walks one terminal-input line token by token, handshaking with the finder, atoi, inner-interpreter (eforth), comma and data-stack blocks. In interpret mode it executes words and pushes numbers; in compile mode it appends opcodes and multi-byte literals at `here`. Unlike the single-token controller, it loops over the whole line, compiles numbers, reports atoi errors, and counts tokens.

## Interface
- TIB, 'h0, terminal input buffer start address
- MSZ, 8, memory data width (bits per byte transaction)
- DSZ, 32, data path / literal width; NB = DSZ/MSZ literal bytes
- ASZ, 17, address width
- LIT_OP, 'h02, opcode emitted before a compiled NB-byte literal
- LIT8_OP, 'h03, opcode for short literal (see Configuration)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- en  in  1  run; low aborts to IDLE next cycle
- cmp  in  1  1 = compile mode, 0 = interpret; sampled per token
- ctx0, here0  in  ASZ  context and dictionary top, loaded at line start
- fdr_en  out  1; fdr_aw  out  ASZ (= tib); fdr_ctx  out  ASZ
- fdr_bsy, fdr_hit  in  1; fdr_vw  in  MSZ (opcode on hit, first char on miss, 0 = end of line); fdr_tib  in  ASZ (tib after token)
- a2i_en  out  1; a2i_tib  out  ASZ; a2i_bsy, a2i_err  in  1; a2i_vo  in  DSZ; a2i_tib_o  in  ASZ
- exe_en  out  1; exe_pfa  out  ASZ; exe_op  out  MSZ; exe_bsy  in  1
- cma_en  out  1; cma_ai  out  ASZ; cma_vi  out  MSZ; cma_bsy  in  1
- ss_push  out  1 (one-cycle pulse); ss_v  out  DSZ
- tib, here  out  ASZ; bsy, err  out  1; tok_cnt  out  8

## Operation
- States: IDLE, FND, EXE, CMA, A2I, LIT, NUM, PSH, ERR, DONE.
- Sub-block handshake: `xx_en` is high every cycle of the owning state. The first cycle of a state ignores `xx_bsy`. Completion is the first later cycle with `xx_bsy`=0.
- IDLE & en: load ctx<=ctx0, here<=here0, tib<=TIB, err<=0, tok_cnt<=0; go to FND.
- FND done:
  - tib<=fdr_tib.
  - On hit, latch op/pfa and go to CMA if cmp, else EXE.
  - On miss with fdr_vw≠0, go to A2I (a2i_tib=fdr_tib).
  - On miss with fdr_vw=0, go to DONE.
- EXE done: tok_cnt++, back to FND.
- CMA: write op at here; on done, here+1, tok_cnt++, go to FND.
- A2I done:
  - a2i_err=1: go to ERR.
  - Otherwise tib<=a2i_tib_o and latch value v.
  - cmp: go to LIT. Else go to PSH.
- PSH: one cycle, ss_push=1, ss_v=v, tok_cnt++, go to FND.
- LIT: write LIT_OP at here, here+1, then go to NUM.
- NUM: NB byte transactions, little-endian (byte k = v[k*MSZ +: MSZ]) at here+k, with an internal byte counter. After the last byte, here+=NB, tok_cnt++, go to FND.
- ERR: err=1, tib<=TIB, bsy=0; hold until en low.
- DONE: tib<=TIB, bsy=0; hold until en low.
- bsy=1 in every state except IDLE, ERR, DONE.
- here, tib and address sums wrap modulo 2^ASZ. tok_cnt wraps at 256.

## Timing
- Reset (rst=0 at clk edge): state IDLE; all outputs 0 except tib=TIB; here=0.
- en low in any state: IDLE next cycle, and all `xx_en` drop that cycle. The here/tib partial updates already made are kept.
- Minimum per-token latency, with sub-blocks finishing on their second cycle:
  - interpret number: FND 2 + A2I 2 + PSH 1 = 5 cycles.
  - compiled word: 4 cycles.
- Compiled literal costs 2·(NB+1) cycles beyond A2I.
- Only one `xx_en` is high in any cycle.
- `cmp` changes take effect at the next FND completion.

## Configuration
- OUTER_SHORT_LIT_EN defined: a compiled value with v < 2^MSZ emits LIT8_OP plus one byte (here+=2). Larger values use LIT_OP plus NB bytes.
- OUTER_SHORT_LIT_EN undefined: every compiled value uses LIT_OP plus NB bytes.

## Test plan
- Interpret "5 7" then end of line, finder misses, atoi returns 5 then 7:
  - ss_push pulses with ss_v=5, then 7; DONE with tok_cnt=2, tib=TIB, bsy=0.
- Interpret word hit, fdr_vw='h21, exe_bsy high 3 cycles:
  - exe_op='h21, exe_pfa latched; return to FND after exe_bsy falls; tok_cnt=1.
- Compile, here0='h100, number 'h12345678, NB=4, macro undefined:
  - cma writes 02,78,56,34,12 at 'h100–'h104; here='h105.
- Same with OUTER_SHORT_LIT_EN, value 'h2A:
  - writes 03,2A at 'h100–'h101; here='h102.
- atoi error on token "1x":
  - ERR, err=1, bsy=0, tib=TIB; en low → IDLE; en high → err cleared.
- Abort and reset:
  - en dropped mid-NUM: IDLE next cycle, cma_en=0.
  - rst=0 in EXE: all outputs zero, tib=TIB next edge.
